stage_stream_fifo: RTL and testbench

STAGE_STREAM_FIFO -- requirements
Module: stage_stream_fifo

---
 rtl/stage_stream_fifo_if.sv | 31 +++
 rtl/stage_stream_fifo.sv | 107 ++++++++++
 tb/tb_stage_stream_fifo.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_stream_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_stream_fifo_if
// Brief    : Write-side and read-side stream handshake of stage_stream_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface stage_stream_fifo_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_fst;
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] out_data;
  logic             out_fst;
  logic             out_vld;
  logic             out_rdy;

  // master: the producer/consumer environment around the FIFO
  modport master (
    output in_data, in_fst, in_vld, out_rdy,
    input  in_rdy, out_data, out_fst, out_vld
  );

  // slave: the FIFO itself
  modport slave (
    input  in_data, in_fst, in_vld, out_rdy,
    output in_rdy, out_data, out_fst, out_vld
  );
endinterface
`default_nettype wire

// File: rtl/stage_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stage_stream_fifo
// Brief    : First-word-fall-through stream FIFO with frame (fst) counting.
//            Define STAGE_FIFO_BYPASS_EN for a zero-latency empty bypass.
// Revision : 1.0 - initial release
// ============================================================================
module stage_stream_fifo #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   flush,
  stage_stream_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        afull,
  output logic [$clog2(DEPTH):0]      frames
);

  localparam int            c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0] c_one   = (c_aw + 1)'(1);
  localparam logic [c_aw:0] c_afull = (c_aw + 1)'(AFULL_THRESH);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic [c_aw:0]   r_frames;

  logic [WIDTH:0]  w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_head_vld;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_fst_in;
  logic            w_fst_out;

  assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

  always_comb begin
    bus.in_rdy   = !w_full && !flush && reset;
    w_head_vld   = !w_empty && !flush && reset;
    w_bypass     = 1'b0;
    bus.out_vld  = w_head_vld;
    bus.out_data = w_head[WIDTH-1:0];
    bus.out_fst  = w_head_vld && w_head[WIDTH];
`ifdef STAGE_FIFO_BYPASS_EN
    // Empty FIFO with a ready consumer: hand the word straight through unstored
    w_bypass = w_empty && bus.in_vld && bus.in_rdy && bus.out_rdy;
    if (w_bypass) begin
      bus.out_vld  = 1'b1;
      bus.out_data = bus.in_data;
      bus.out_fst  = bus.in_fst;
    end
`endif
    w_push    = bus.in_vld && bus.in_rdy && !w_bypass;
    w_pop     = w_head_vld && bus.out_rdy;
    w_fst_in  = w_push && bus.in_fst;
    w_fst_out = w_pop && w_head[WIDTH];
  end

  // Storage is deliberately left out of reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {bus.in_fst, bus.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_frames <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_one;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + c_one;
      end else if (!w_push && w_pop) begin
        r_level <= r_level - c_one;
      end
      if (w_fst_in && !w_fst_out) begin
        r_frames <= r_frames + c_one;
      end else if (!w_fst_in && w_fst_out) begin
        r_frames <= r_frames - c_one;
      end
    end
  end

  assign level  = r_level;
  assign frames = r_frames;
  assign afull  = (r_level >= c_afull);

endmodule
`default_nettype wire

// File: tb/tb_stage_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_stream_fifo
// Brief    : Directed self-checking bench for stage_stream_fifo (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_stream_fifo;

  localparam int c_width = 32;
  localparam int c_depth = 16;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [4:0] level;
  logic       afull;
  logic [4:0] frames;
  int         n_tests;
  int         n_fail;

  stage_stream_fifo_if #(.WIDTH(c_width)) bus ();

  stage_stream_fifo #(
    .WIDTH (c_width),
    .DEPTH (c_depth)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .bus    (bus),
    .level  (level),
    .afull  (afull),
    .frames (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge, then let outputs settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wi;
    int ri;
    int guard;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    flush = 1'b0;
    bus.in_data = '0;
    bus.in_fst  = 1'b0;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;

    // reset state
    cyc();
    cyc();
    chk("rst_in_rdy", 40'(bus.in_rdy), 40'h0);
    chk("rst_out_vld", 40'(bus.out_vld), 40'h0);
    chk("rst_out_fst", 40'(bus.out_fst), 40'h0);
    chk("rst_level", 40'(level), 40'h0);
    chk("rst_frames", 40'(frames), 40'h0);
    chk("rst_afull", 40'(afull), 40'h0);
    reset = 1'b1;
    #1;
    chk("rel_in_rdy", 40'(bus.in_rdy), 40'h1);

    // fill to full with consumer stalled
    bus.in_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 32'h3F80_0000 + 32'(i);
      #1;
      chk("fill_in_rdy", 40'(bus.in_rdy), 40'h1);
      cyc();
      chk("fill_level", 40'(level), 40'(i + 1));
      chk("fill_afull", 40'(afull), 40'((i + 1) >= 12));
    end
    chk("full_in_rdy", 40'(bus.in_rdy), 40'h0);
    bus.in_data = 32'h0000_0BAD;
    cyc();
    chk("full_no_push", 40'(level), 40'd16);

    // drain; first cycle also offers a word that must be refused at full
    bus.out_rdy = 1'b1;
    #1;
    chk("full_pop_in_rdy", 40'(bus.in_rdy), 40'h0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_vld", 40'(bus.out_vld), 40'h1);
      chk("drain_data", 40'(bus.out_data), 40'(32'h3F80_0000 + 32'(i)));
      cyc();
      bus.in_vld = 1'b0;
      #1;
      chk("drain_level", 40'(level), 40'(15 - i));
    end
    chk("drain_empty_vld", 40'(bus.out_vld), 40'h0);
    chk("drain_afull", 40'(afull), 40'h0);

    // continuous stream across pointer wrap
    wi = 0;
    ri = 0;
    bus.in_vld = 1'b1;
    while (wi < 40) begin
      bus.in_data = 32'h5000_0000 + 32'(wi);
      #1;
      chk("strm_in_rdy", 40'(bus.in_rdy), 40'h1);
`ifdef STAGE_FIFO_BYPASS_EN
      chk("strm_vld", 40'(bus.out_vld), 40'h1);
`else
      chk("strm_vld", 40'(bus.out_vld), 40'(wi > 0));
`endif
      if (bus.out_vld) begin
        chk("strm_data", 40'(bus.out_data), 40'(32'h5000_0000 + 32'(ri)));
        ri++;
      end
      cyc();
      wi++;
      chk("strm_level", 40'(level <= 5'd1), 40'h1);
    end
    bus.in_vld = 1'b0;
    guard = 0;
    #1;
    while (ri < 40 && guard < 4) begin
      if (bus.out_vld) begin
        chk("strm_tail", 40'(bus.out_data), 40'(32'h5000_0000 + 32'(ri)));
        ri++;
      end
      cyc();
      guard++;
    end
    chk("strm_count", 40'(ri), 40'd40);
    chk("strm_level_end", 40'(level), 40'h0);

    // frame counting
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 32'h100 + 32'(i);
      bus.in_fst  = (i == 0 || i == 4 || i == 8);
      cyc();
    end
    bus.in_vld = 1'b0;
    bus.in_fst = 1'b0;
    #1;
    chk("frm_frames3", 40'(frames), 40'd3);
    chk("frm_level10", 40'(level), 40'd10);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("frm_out_data", 40'(bus.out_data), 40'(32'h100 + 32'(i)));
      chk("frm_out_fst", 40'(bus.out_fst), 40'(i == 0 || i == 4));
      cyc();
    end
    chk("frm_frames1", 40'(frames), 40'd1);
    bus.out_rdy = 1'b0;

    // flush at level 7 overrides a concurrent push and pop
    bus.in_vld  = 1'b1;
    bus.in_data = 32'h0000_0777;
    cyc();
    cyc();
    chk("fl_level7", 40'(level), 40'd7);
    flush = 1'b1;
    bus.out_rdy = 1'b1;
    #1;
    chk("fl_out_vld", 40'(bus.out_vld), 40'h0);
    chk("fl_in_rdy", 40'(bus.in_rdy), 40'h0);
    cyc();
    flush = 1'b0;
    bus.in_vld = 1'b0;
    #1;
    chk("fl_level0", 40'(level), 40'h0);
    chk("fl_frames0", 40'(frames), 40'h0);
    chk("fl_vld0", 40'(bus.out_vld), 40'h0);

    // reset mid-operation at level 5
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 32'h200 + 32'(i);
      bus.in_fst  = (i == 1);
      cyc();
    end
    bus.in_vld = 1'b0;
    bus.in_fst = 1'b0;
    #1;
    chk("mr_level5", 40'(level), 40'd5);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("mr_level0", 40'(level), 40'h0);
    chk("mr_frames0", 40'(frames), 40'h0);
    chk("mr_vld0", 40'(bus.out_vld), 40'h0);
    bus.in_vld  = 1'b1;
    bus.in_data = 32'hDEAD_BEEF;
    cyc();
    bus.in_vld = 1'b0;
    #1;
    chk("mr_vld1", 40'(bus.out_vld), 40'h1);
    chk("mr_data", 40'(bus.out_data), 40'h00_DEAD_BEEF);
    chk("mr_level1", 40'(level), 40'h1);
    bus.out_rdy = 1'b1;
    cyc();
    chk("mr_drained", 40'(level), 40'h0);

    // empty FIFO, ready consumer: bypass versus one-cycle latency
    bus.in_vld  = 1'b1;
    bus.in_data = 32'h4049_0FDB;
    #1;
`ifdef STAGE_FIFO_BYPASS_EN
    chk("bp_vld_same", 40'(bus.out_vld), 40'h1);
    chk("bp_data_same", 40'(bus.out_data), 40'h00_4049_0FDB);
    cyc();
    bus.in_vld = 1'b0;
    #1;
    chk("bp_level0", 40'(level), 40'h0);
    chk("bp_vld_after", 40'(bus.out_vld), 40'h0);
`else
    chk("bp_vld_same", 40'(bus.out_vld), 40'h0);
    cyc();
    bus.in_vld = 1'b0;
    #1;
    chk("bp_vld_next", 40'(bus.out_vld), 40'h1);
    chk("bp_data_next", 40'(bus.out_data), 40'h00_4049_0FDB);
    chk("bp_level1", 40'(level), 40'h1);
    cyc();
    chk("bp_level0", 40'(level), 40'h0);
    chk("bp_vld_after", 40'(bus.out_vld), 40'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
